// File: rtl/lookahead_mp_sequencer.sv
// rtl/lookahead_mp_sequencer.sv - multi-precision add sequencer driving an external 16-bit lookahead adder
// Optional feature macro: MPADD_SUB_EN (adds the sub port for A-B operation).
module lookahead_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS*16-1:0]   operand1,
    input  logic [WORDS*16-1:0]   operand2,
    input  logic                  Cin,
`ifdef MPADD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDS*16-1:0]   Result,
    output logic                  Cout,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int DW = WORDS * 16;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic          carry;
    logic [15:0]   a_slice;
    logic [15:0]   b_slice;
    logic          sub_reg;
    logic          start_carry;

`ifdef MPADD_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced high.
    assign start_carry = sub ? 1'b1 : Cin;
`else
    assign start_carry = Cin;
`endif

    assign in_ready = (state == S_IDLE);

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) begin
                a_slice = a_reg[w*16 +: 16];
                b_slice = b_reg[w*16 +: 16];
            end
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_slice;
            add_b   = sub_reg ? ~b_slice : b_slice;
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            sub_reg   <= 1'b0;
            Result    <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= operand1;
                        b_reg   <= operand2;
                        carry   <= start_carry;
`ifdef MPADD_SUB_EN
                        sub_reg <= sub;
`else
                        sub_reg <= 1'b0;
`endif
                        idx     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IW'(w)) begin
                            Result[w*16 +: 16] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    // Exit on the last slice so idx never wraps.
                    if (idx == IW'(WORDS - 1)) begin
                        Cout      <= add_cout;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lookahead_mp_sequencer.sv
// tb/tb_lookahead_mp_sequencer.sv - directed and random checks of lookahead_mp_sequencer with a behavioural 16-bit adder
module tb_lookahead_mp_sequencer;

    localparam int WORDS = 4;
    localparam int DW    = WORDS * 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] operand1;
    logic [DW-1:0] operand2;
    logic          Cin;
`ifdef MPADD_SUB_EN
    logic          sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Result;
    logic          Cout;
    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_cin;
    logic [15:0]   add_sum;
    logic          add_cout;
    logic [16:0]   add_full;

    int checks = 0;
    int errors = 0;

    lookahead_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .Cin       (Cin),
`ifdef MPADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Cout      (Cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign add_sum  = add_full[15:0];
    assign add_cout = add_full[16];

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c, output int cyc);
        operand1 = a;
        operand2 = b;
        Cin      = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        operand1 = ~a;
        operand2 = ~b;
        Cin      = ~c;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand1 = '0; operand2 = '0; Cin = 1'b0;
`ifdef MPADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (Result !== '0 || Cout !== 1'b0) begin
            errors++; $display("FAIL reset_result: Result=%h Cout=%b required 0/0", Result, Cout);
        end
        checks++;
        if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin
            errors++; $display("FAIL reset_adder_ports: a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_carry();
        int cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_carry_in_ready: in_ready=%b required 1", in_ready);
        end
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, cyc);
        checks++;
        if (cyc !== 4) begin
            errors++; $display("FAIL full_carry_latency: cycles=%0d required 4", cyc);
        end
        checks++;
        if (Result !== 64'h0 || Cout !== 1'b1) begin
            errors++; $display("FAIL full_carry_sum: Result=%h Cout=%b required 0/1", Result, Cout);
        end
        checks++;
        if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin
            errors++; $display("FAIL done_adder_ports: a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL full_carry_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_inter_word();
        int cyc;
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, cyc);
        checks++;
        if (cyc !== 4 || Result !== 64'h0000_0000_0001_0000 || Cout !== 1'b0) begin
            errors++; $display("FAIL inter_word: cycles=%0d Result=%h Cout=%b required 4/0000000000010000/0", cyc, Result, Cout);
        end
        release_result();
    endtask

    task automatic test_pattern_cin();
        int cyc;
        do_op(64'hA0A0_A0A0_A0A0_A0A0, 64'hA0A0_A0A0_A0A0_A0A0, 1'b1, cyc);
        checks++;
        if (cyc !== 4 || Result !== 64'h4141_4141_4141_4141 || Cout !== 1'b1) begin
            errors++; $display("FAIL pattern_cin: cycles=%0d Result=%h Cout=%b required 4/4141414141414141/1", cyc, Result, Cout);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, cyc);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            operand1 = 64'h5555_5555_5555_5555;
            operand2 = 64'h5555_5555_5555_5555;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold_%0d: out_valid=%b in_ready=%b required 1/0", i, out_valid, in_ready);
            end
            checks++;
            if (Result !== 64'h1234_5678_9ABC_DF00 || Cout !== 1'b0) begin
                errors++; $display("FAIL backpressure_stable_%0d: Result=%h Cout=%b required 123456789abcdf00/0", i, Result, Cout);
            end
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== 64'h1234_5678_9ABC_DF00) begin
            errors++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b Result=%h required 0/1/123456789abcdf00", out_valid, in_ready, Result);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_no_accept: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        operand1 = 64'hA0A0_A0A0_A0A0_A0A0;
        operand2 = 64'hA0A0_A0A0_A0A0_A0A0;
        Cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (add_a !== 16'hA0A0 || add_cin !== 1'b1) begin
            errors++; $display("FAIL mid_run_slice: add_a=%h add_cin=%b required a0a0/1", add_a, add_cin);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Result !== '0 || Cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_run_reset: out_valid=%b Result=%h Cout=%b in_ready=%b required 0/0/0/1", out_valid, Result, Cout, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, cyc);
        checks++;
        if (cyc !== 4 || Result !== 64'h0 || Cout !== 1'b1) begin
            errors++; $display("FAIL post_reset_op: cycles=%0d Result=%h Cout=%b required 4/0/1", cyc, Result, Cout);
        end
        release_result();
    endtask

`ifdef MPADD_SUB_EN
    task automatic test_sub();
        int cyc;
        sub = 1'b1;
        do_op(64'd5, 64'd7, 1'b0, cyc);
        sub = 1'b0;
        checks++;
        if (cyc !== 4 || Result !== 64'hFFFF_FFFF_FFFF_FFFE || Cout !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: cycles=%0d Result=%h Cout=%b required 4/fffffffffffffffe/0", cyc, Result, Cout);
        end
        release_result();
        sub = 1'b1;
        do_op(64'd7, 64'd5, 1'b1, cyc);
        sub = 1'b0;
        checks++;
        if (Result !== 64'd2 || Cout !== 1'b1) begin
            errors++; $display("FAIL sub_no_borrow: Result=%h Cout=%b required 2/1", Result, Cout);
        end
        release_result();
    endtask
`endif

    task automatic test_random();
        int            cyc;
        int            stall;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          c;
        logic [DW:0]   expv;
        for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            if (n % 50 == 0) a = '1;
            expv = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
            do_op(a, b, c, cyc);
            checks++;
            if (cyc !== 4 || {Cout, Result} !== expv) begin
                errors++; $display("FAIL random_%0d: cycles=%0d got=%h required 4/%h", n, cyc, {Cout, Result}, expv);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || {Cout, Result} !== expv) begin
                    errors++; $display("FAIL random_stall_%0d: out_valid=%b got=%h required 1/%h", n, out_valid, {Cout, Result}, expv);
                end
            end
            release_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL random_release_%0d: out_valid=%b in_ready=%b required 0/1", n, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_carry();
        test_inter_word();
        test_pattern_cin();
        test_backpressure();
        test_reset_mid_run();
`ifdef MPADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
